// File: rtl/reg_dump_pkg.sv
// Shared types and default widths for the register-file dump engine.
package reg_dump_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_dump_csum.sv
// Clearable, enable-gated modular accumulator for the dump checksum beat.
module reg_dump_csum #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] sum
);

    // Sum wraps naturally at 2^DW.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/reg_dump.sv
// Streams register-file contents FIRST..LAST over a valid/ready port.
// Define REG_DUMP_CHECKSUM_EN to append a modular-sum checksum beat.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned FIRST = 0,
    parameter int unsigned LAST  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_nxt;
    logic          valid_nxt;
    logic          last_nxt;
    logic [AW-1:0] oaddr_nxt;
    logic [DW-1:0] odata_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          at_last;

    assign ra      = addr;
    assign at_last = (addr == AW'(LAST));

`ifdef REG_DUMP_CHECKSUM_EN
    logic          csum_clr;
    logic          csum_en;
    logic [DW-1:0] csum;

    assign csum_clr = (state == ST_IDLE) && start;
    assign csum_en  = (state == ST_FETCH);

    reg_dump_csum #(
        .DW (DW)
    ) u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (csum_clr),
        .en    (csum_en),
        .din   (rd),
        .sum   (csum)
    );
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        oaddr_nxt = out_addr;
        odata_nxt = out_data;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt  = AW'(FIRST);
                    state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                odata_nxt = rd;
                oaddr_nxt = addr;
                valid_nxt = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                last_nxt  = 1'b0;
`else
                last_nxt  = at_last;
`endif
                state_nxt = ST_SEND;
            end

            ST_SEND: begin
                valid_nxt = 1'b1;
                last_nxt  = out_last;
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        valid_nxt = 1'b1;
                        last_nxt  = 1'b1;
                        oaddr_nxt = AW'(LAST);
                        odata_nxt = csum;
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        addr_nxt  = addr + AW'(1);
                        state_nxt = ST_FETCH;
                    end
                end
            end

`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                valid_nxt = 1'b1;
                last_nxt  = 1'b1;
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    state_nxt = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                addr_nxt  = AW'(FIRST);
                state_nxt = ST_IDLE;
            end

            default: begin
                addr_nxt  = AW'(FIRST);
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr      <= AW'(FIRST);
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            out_valid <= valid_nxt;
            out_addr  <= oaddr_nxt;
            out_data  <= odata_nxt;
            out_last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed self-checking bench for reg_dump: full dump, backpressure, ignored
// start, mid-dump write, mid-dump reset and a single-register window.
module tb_reg_dump;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM_ON = 1;
`else
    localparam int CSUM_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_a, start_b;
    logic          ready_a, ready_b;
    logic [AW-1:0] ra_a, ra_b, oaddr_a, oaddr_b;
    logic [DW-1:0] rd_a, rd_b, odata_a, odata_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic          valid_a, valid_b, last_a, last_b;

    logic [DW-1:0] regs    [16];
    logic [DW-1:0] exp_mem [16];

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];

    reg_dump #(.DW(DW), .AW(AW), .FIRST(0), .LAST(15)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ra(ra_a), .rd(rd_a),
        .busy(busy_a), .done(done_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_addr(oaddr_a), .out_data(odata_a), .out_last(last_a)
    );

    reg_dump #(.DW(DW), .AW(AW), .FIRST(2), .LAST(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ra(ra_b), .rd(rd_b),
        .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_addr(oaddr_b), .out_data(odata_b), .out_last(last_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs();
        for (int i = 0; i < 16; i++) begin
            regs[i]    = 8'(i * 17);
            exp_mem[i] = 8'(i * 17);
        end
    endtask

    // One dump on dut_a with optional stall, stray start and register write hooks.
    task automatic run_a(input string tag, input int stall_addr, input int stall_len,
                         input int poke_addr, input int wr_addr, input logic [7:0] wr_val);
        int         nbeats   = 0;
        int         ndone    = 0;
        int         done_cyc = -1;
        int         c;
        bit         stalled  = 1'b0;
        bit         wrote    = 1'b0;
        logic [7:0] sum      = 8'h00;
        logic [3:0] haddr;
        logic [7:0] hdata;

        for (int i = 0; i < 16; i++) sum = 8'(sum + exp_mem[i]);
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        c = 1;
        while (c < 70) begin
            start_a = 1'b0;
            if (stall_len == 0 && (c % 2) == 1 && c < 32)
                check($sformatf("%s ra c%0d", tag, c), 32'(ra_a), 32'(c / 2));
            if (valid_a && int'(oaddr_a) == wr_addr - 1 && !wrote) begin
                regs[wr_addr] = wr_val;
                wrote = 1'b1;
            end
            if (valid_a && int'(oaddr_a) == poke_addr) start_a = 1'b1;
            if (valid_a && int'(oaddr_a) == stall_addr && !stalled) begin
                stalled = 1'b1;
                ready_a = 1'b0;
                haddr   = oaddr_a;
                hdata   = odata_a;
                repeat (stall_len) begin
                    tick();
                    c++;
                    check($sformatf("%s hold valid", tag), 32'(valid_a), 32'd1);
                    check($sformatf("%s hold addr", tag), 32'(oaddr_a), 32'(haddr));
                    check($sformatf("%s hold data", tag), 32'(odata_a), 32'(hdata));
                end
                ready_a = 1'b1;
            end
            if (valid_a) begin
                if (nbeats < 16) begin
                    check($sformatf("%s addr b%0d", tag, nbeats), 32'(oaddr_a), 32'(nbeats));
                    check($sformatf("%s data b%0d", tag, nbeats), 32'(odata_a), 32'(exp_mem[nbeats]));
                    check($sformatf("%s last b%0d", tag, nbeats), 32'(last_a),
                          32'((nbeats == 15 && CSUM_ON == 0) ? 1 : 0));
                end else begin
                    check($sformatf("%s csum addr", tag), 32'(oaddr_a), 32'd15);
                    check($sformatf("%s csum data", tag), 32'(odata_a), 32'(sum));
                    check($sformatf("%s csum last", tag), 32'(last_a), 32'd1);
                end
                nbeats++;
            end
            if (done_a) begin
                ndone++;
                done_cyc = c;
            end
            tick();
            c++;
        end
        check($sformatf("%s beats", tag), 32'(nbeats), 32'(16 + CSUM_ON));
        check($sformatf("%s ndone", tag), 32'(ndone), 32'd1);
        check($sformatf("%s done cycle", tag), 32'(done_cyc), 32'(34 + stall_len + CSUM_ON));
        check($sformatf("%s busy end", tag), 32'(busy_a), 32'd0);
        check($sformatf("%s valid end", tag), 32'(valid_a), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        int nb;
        int nd;
        int dcyc;

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        load_regs();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        check("rst valid", 32'(valid_a), 32'd0);
        check("rst addr", 32'(oaddr_a), 32'd0);
        check("rst data", 32'(odata_a), 32'd0);
        check("rst last", 32'(last_a), 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst done", 32'(done_a), 32'd0);
        check("rst ra", 32'(ra_a), 32'd0);
        check("rst ra b", 32'(ra_b), 32'd2);

        // Full dump 0..15 with ready tied high.
        load_regs();
        run_a("full", -1, 0, -1, -1, 8'h00);

        // Five-cycle stall on the addr 3 beat.
        load_regs();
        run_a("stall", 3, 5, -1, -1, 8'h00);

        // Stray start during the addr 5 beat.
        load_regs();
        run_a("ignore", -1, 0, 5, -1, 8'h00);

        // R9 rewritten one cycle before its fetch.
        load_regs();
        exp_mem[9] = 8'h3C;
        run_a("wr9", -1, 0, -1, 9, 8'h3C);

        // Reset while the addr 7 beat is pending.
        load_regs();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!(valid_a && oaddr_a == 4'd7) && k < 40) begin
            tick();
            k++;
        end
        check("rst7 reached", 32'(valid_a && oaddr_a == 4'd7), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst7 valid", 32'(valid_a), 32'd0);
        check("rst7 addr", 32'(oaddr_a), 32'd0);
        check("rst7 data", 32'(odata_a), 32'd0);
        check("rst7 last", 32'(last_a), 32'd0);
        check("rst7 busy", 32'(busy_a), 32'd0);
        check("rst7 done", 32'(done_a), 32'd0);
        check("rst7 ra", 32'(ra_a), 32'd0);
        bad = 0;
        repeat (10) begin
            if (done_a || valid_a || busy_a) bad++;
            tick();
        end
        check("rst7 quiet", 32'(bad), 32'd0);
        run_a("restart", -1, 0, -1, -1, 8'h00);

        // Single-register window FIRST=LAST=2.
        regs[2] = 8'hA5;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        nb   = 0;
        nd   = 0;
        dcyc = -1;
        for (int c = 1; c < 20; c++) begin
            if (valid_b) begin
                check($sformatf("win addr b%0d", nb), 32'(oaddr_b), 32'd2);
                check($sformatf("win data b%0d", nb), 32'(odata_b), 32'hA5);
                check($sformatf("win last b%0d", nb), 32'(last_b),
                      32'((nb == CSUM_ON) ? 1 : 0));
                nb++;
            end
            if (done_b) begin
                nd++;
                dcyc = c;
            end
            tick();
        end
        check("win beats", 32'(nb), 32'(1 + CSUM_ON));
        check("win ndone", 32'(nd), 32'd1);
        check("win done cycle", 32'(dcyc), 32'(4 + CSUM_ON));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
